// File: rtl/gcd_proc_sequencer.sv
// Purpose: shares one subtract-loop GCD Processor between two requesters (round-robin),
//          sequences Processor reset / X entry / Y entry, waits for halt, returns result.
// Latency: first enter pulse 1+PRST_CYCLES+PRE_X_CYCLES cycles after the grant cycle;
//          the Y pulse follows X by X_TO_Y_CYCLES+1 cycles; RUN lasts at most TIMEOUT cycles.
// Backpressure: one job in flight; the result is held in DONE until rsp_ready, and no new
//          grant is issued before that, so waiting requesters simply keep req_valid high.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester job handshake (bit i = requester i)
//   req{0,1}_x/_y         8-bit operands of each requester
//   rsp_valid/rsp_ready   result handshake; rsp_data/rsp_id/rsp_err stable while valid
//   busy                  high whenever the sequencer is not idle
//   proc_reset/enter/in   drive the Processor (reset is active-low)
//   proc_out/proc_halt    Processor result and done flag
module gcd_proc_sequencer #(
  parameter int unsigned PRST_CYCLES   = 1,
  parameter int unsigned PRE_X_CYCLES  = 4,
  parameter int unsigned X_TO_Y_CYCLES = 7,
  parameter int unsigned TIMEOUT       = 4095
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req0_x,
  input  logic [7:0] req0_y,
  input  logic [7:0] req1_x,
  input  logic [7:0] req1_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  output logic       rsp_err,
  output logic       busy,
  output logic       proc_reset,
  output logic       proc_enter,
  output logic [7:0] proc_in,
  input  logic [7:0] proc_out,
  input  logic       proc_halt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRST,
    S_WAITX,
    S_ENTX,
    S_WAITY,
    S_ENTY,
    S_RUN,
    S_DONE
  } state_e;

  // Timed states load N-1 and leave when the counter reads zero, so each lasts N cycles.
  localparam logic [15:0] PRST_LD  = 16'(PRST_CYCLES - 1);
  localparam logic [15:0] PREX_LD  = 16'(PRE_X_CYCLES - 1);
  localparam logic [15:0] XTOY_LD  = 16'(X_TO_Y_CYCLES - 1);
  localparam logic [15:0] TIMEO_LD = 16'(TIMEOUT);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic        last_grant_q;
  logic [7:0]  x_q;
  logic [7:0]  y_q;

  logic        rsp_valid_q;
  logic [7:0]  rsp_data_q;
  logic        rsp_id_q;
  logic        rsp_err_q;
  logic        busy_q;
  logic        proc_reset_q;
  logic        proc_enter_q;
  logic [7:0]  proc_in_q;

  // Round-robin pick: the requester after last_grant has priority; a lone valid always wins.
  logic [1:0]  grant_d;
  logic [7:0]  sel_x_d;
  logic [7:0]  sel_y_d;

  always_comb begin
    grant_d = 2'b00;
    if (last_grant_q) begin
      if (req_valid[0])      grant_d = 2'b01;
      else if (req_valid[1]) grant_d = 2'b10;
    end else begin
      if (req_valid[1])      grant_d = 2'b10;
      else if (req_valid[0]) grant_d = 2'b01;
    end
  end

  assign sel_x_d = grant_d[1] ? req1_x : req0_x;
  assign sel_y_d = grant_d[1] ? req1_y : req0_y;

  // Ready is the only combinational output: the job transfers in the same IDLE cycle the
  // grant is shown. Gating with reset keeps it low while reset is held.
  assign req_ready = (state_q == S_IDLE && reset) ? grant_d : 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      last_grant_q <= 1'b1;
      x_q          <= 8'd0;
      y_q          <= 8'd0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 8'd0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      proc_reset_q <= 1'b0;
      proc_enter_q <= 1'b0;
      proc_in_q    <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_d != 2'b00) begin
            last_grant_q <= grant_d[1];
            rsp_id_q     <= grant_d[1];
            x_q          <= sel_x_d;
            y_q          <= sel_y_d;
            busy_q       <= 1'b1;
            if (sel_x_d == 8'd0 || sel_y_d == 8'd0) begin
              // The subtract loop never terminates on a zero operand: reject without
              // touching the Processor.
              rsp_data_q  <= 8'd0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              proc_reset_q <= 1'b0;
              cnt_q        <= PRST_LD;
              state_q      <= S_PRST;
            end
          end
        end

        S_PRST: begin
          if (cnt_q == 16'd0) begin
            proc_reset_q <= 1'b1;
            cnt_q        <= PREX_LD;
            state_q      <= S_WAITX;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        S_WAITX: begin
          if (cnt_q == 16'd0) begin
            proc_in_q    <= x_q;
            proc_enter_q <= 1'b1;
            state_q      <= S_ENTX;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        S_ENTX: begin
          // proc_in keeps x through WAITY.
          proc_enter_q <= 1'b0;
          cnt_q        <= XTOY_LD;
          state_q      <= S_WAITY;
        end

        S_WAITY: begin
          if (cnt_q == 16'd0) begin
            proc_in_q    <= y_q;
            proc_enter_q <= 1'b1;
            state_q      <= S_ENTY;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        S_ENTY: begin
          proc_enter_q <= 1'b0;
          cnt_q        <= TIMEO_LD;
          state_q      <= S_RUN;
        end

        S_RUN: begin
          // Counter holds the number of RUN cycles left including this one; halt wins a tie.
          if (proc_halt) begin
            rsp_data_q  <= proc_out;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (cnt_q <= 16'd1) begin
            rsp_data_q  <= 8'd0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        S_DONE: begin
          // Processor stays out of reset here so its output remains observable.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign proc_reset = proc_reset_q;
  assign proc_enter = proc_enter_q;
  assign proc_in    = proc_in_q;

endmodule

// File: tb/tb_gcd_proc_sequencer.sv
module tb_gcd_proc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // Main instance, default timing, driven against a subtract-loop Processor model.
  logic [1:0] req_valid, req_ready;
  logic [7:0] req0_x, req0_y, req1_x, req1_y;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [7:0] rsp_data;
  logic       proc_reset, proc_enter, proc_halt;
  logic [7:0] proc_in, proc_out;

  // Second instance with TIMEOUT=20 and a Processor whose halt never rises.
  logic [1:0] t_req_valid, t_req_ready;
  logic [7:0] t_req0_x, t_req0_y, t_req1_x, t_req1_y;
  logic       t_rsp_valid, t_rsp_ready, t_rsp_id, t_rsp_err, t_busy;
  logic [7:0] t_rsp_data;
  logic       t_proc_reset, t_proc_enter;
  logic [7:0] t_proc_in;
  logic [7:0] t_proc_out = 8'd0;
  logic       t_proc_halt = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  gcd_proc_sequencer dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req1_x(req1_x), .req1_y(req1_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy),
    .proc_reset(proc_reset), .proc_enter(proc_enter), .proc_in(proc_in),
    .proc_out(proc_out), .proc_halt(proc_halt)
  );

  gcd_proc_sequencer #(.TIMEOUT(20)) dut_t (
    .clk(clk), .reset(rst_n),
    .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req0_x(t_req0_x), .req0_y(t_req0_y), .req1_x(t_req1_x), .req1_y(t_req1_y),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data),
    .rsp_id(t_rsp_id), .rsp_err(t_rsp_err), .busy(t_busy),
    .proc_reset(t_proc_reset), .proc_enter(t_proc_enter), .proc_in(t_proc_in),
    .proc_out(t_proc_out), .proc_halt(t_proc_halt)
  );

  // Processor model: first enter loads X, second loads Y, then one subtraction per cycle.
  logic [7:0] px = 8'd0, py = 8'd0;
  logic [1:0] pn = 2'd0;
  logic       ph = 1'b0;
  always @(posedge clk) begin
    if (!proc_reset) begin
      px <= 8'd0; py <= 8'd0; pn <= 2'd0; ph <= 1'b0;
    end else if (proc_enter) begin
      if (pn == 2'd0) px <= proc_in; else py <= proc_in;
      pn <= pn + 2'd1;
    end else if (pn == 2'd2 && !ph) begin
      if (px > py)      px <= px - py;
      else if (py > px) py <= py - px;
      else              ph <= 1'b1;
    end
  end
  assign proc_halt = ph;
  assign proc_out  = px;

  function automatic logic [7:0] ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b; a = b; b = t;
    end
    return 8'(a);
  endfunction

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      step();
      if (rsp_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11; req0_x = 8'd3; req0_y = 8'd4; req1_x = 8'd5; req1_y = 8'd6;
    t_req_valid = 2'b11; t_req0_x = 8'd1; t_req0_y = 8'd1; t_req1_x = 8'd1; t_req1_y = 8'd1;
    rsp_ready = 1'b1; t_rsp_ready = 1'b1;
    repeat (3) step();
    n_tests++;
    if ({req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy, proc_reset, proc_enter, proc_in} !== 24'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0",
        {req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy, proc_reset, proc_enter, proc_in});
    end
    n_tests++;
    if ({t_req_ready, t_rsp_valid, t_busy, t_proc_reset, t_proc_enter} !== 6'd0) begin
      n_fail++; $display("FAIL reset_outputs_t: got %h want 0",
        {t_req_ready, t_rsp_valid, t_busy, t_proc_reset, t_proc_enter});
    end
    req_valid = 2'b00; t_req_valid = 2'b00;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // req0 (48,18): enter pulses 6 and 14 cycles after the grant cycle, result 6.
  task automatic test_single();
    bit ok;
    step();
    req_valid = 2'b01; req0_x = 8'd48; req0_y = 8'd18; rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b want 01", req_ready); end
    step(); req_valid = 2'b00;
    n_tests++;
    if (proc_reset !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_prst: got reset=%b busy=%b want 0 1", proc_reset, busy);
    end
    step();
    n_tests++;
    if (proc_reset !== 1'b1) begin n_fail++; $display("FAIL single_prst_release: got %b want 1", proc_reset); end
    repeat (3) step();
    n_tests++;
    if (proc_enter !== 1'b0) begin n_fail++; $display("FAIL single_early_enter: got %b want 0", proc_enter); end
    step();
    n_tests++;
    if (proc_enter !== 1'b1 || proc_in !== 8'd48) begin
      n_fail++; $display("FAIL single_enter_x: got en=%b in=%0d want 1 48", proc_enter, proc_in);
    end
    step();
    n_tests++;
    if (proc_enter !== 1'b0 || proc_in !== 8'd48) begin
      n_fail++; $display("FAIL single_waity: got en=%b in=%0d want 0 48", proc_enter, proc_in);
    end
    repeat (7) step();
    n_tests++;
    if (proc_enter !== 1'b1 || proc_in !== 8'd18) begin
      n_fail++; $display("FAIL single_enter_y: got en=%b in=%0d want 1 18", proc_enter, proc_in);
    end
    wait_rsp(300, ok);
    n_tests++;
    if (!ok || rsp_data !== 8'd6 || rsp_id !== 1'b0 || rsp_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_rsp: got ok=%b data=%0d id=%b err=%b busy=%b want 1 6 0 0 1",
        ok, rsp_data, rsp_id, rsp_err, busy);
    end
    step();
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_after: got valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  // Both held valid from reset: grants 0,1,0,1 with results 25 and 27.
  task automatic test_round_robin();
    bit ok;
    bit got;
    logic [1:0] exp_g;
    step();
    rst_n = 1'b0;
    req_valid = 2'b11; req0_x = 8'd100; req0_y = 8'd75; req1_x = 8'd81; req1_y = 8'd27;
    rsp_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
    #1;
    for (int j = 0; j < 4; j++) begin
      exp_g = (j % 2 == 0) ? 2'b01 : 2'b10;
      got = (req_ready != 2'b00);
      for (int c = 0; c < 5 && !got; c++) begin
        step();
        got = (req_ready != 2'b00);
      end
      n_tests++;
      if (!got || req_ready !== exp_g) begin
        n_fail++; $display("FAIL rr_grant%0d: got %b want %b", j, req_ready, exp_g);
      end
      wait_rsp(400, ok);
      n_tests++;
      if (!ok || rsp_data !== (j % 2 == 0 ? 8'd25 : 8'd27) || rsp_id !== exp_g[1] || rsp_err !== 1'b0) begin
        n_fail++; $display("FAIL rr_rsp%0d: got ok=%b data=%0d id=%b err=%b want 1 %0d %b 0",
          j, ok, rsp_data, rsp_id, rsp_err, (j % 2 == 0 ? 25 : 27), exp_g[1]);
      end
      if (j == 3) req_valid = 2'b00;
    end
    step();
  endtask

  // req1 (7,0): immediate error response, Processor untouched.
  task automatic test_zero_operand();
    logic pr_before;
    step();
    pr_before = proc_reset;
    req_valid = 2'b10; req1_x = 8'd7; req1_y = 8'd0;
    #1;
    n_tests++;
    if (req_ready !== 2'b10) begin n_fail++; $display("FAIL zero_ready: got %b want 10", req_ready); end
    step(); req_valid = 2'b00;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 8'd0 || rsp_id !== 1'b1) begin
      n_fail++; $display("FAIL zero_rsp: got v=%b err=%b data=%0d id=%b want 1 1 0 1",
        rsp_valid, rsp_err, rsp_data, rsp_id);
    end
    n_tests++;
    if (proc_reset !== pr_before || proc_enter !== 1'b0) begin
      n_fail++; $display("FAIL zero_proc: got reset=%b enter=%b want %b 0", proc_reset, proc_enter, pr_before);
    end
    step();
    n_tests++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL zero_one_cycle: got %b want 0", rsp_valid); end
  endtask

  // TIMEOUT=20, halt never rises: RUN spans the 20 cycles after the Y pulse, so the error
  // response is visible on the 21st cycle after the Y pulse.
  task automatic test_timeout();
    bit early;
    step();
    t_req_valid = 2'b01; t_req0_x = 8'd5; t_req0_y = 8'd3;
    #1;
    n_tests++;
    if (t_req_ready !== 2'b01) begin n_fail++; $display("FAIL to_ready: got %b want 01", t_req_ready); end
    step(); t_req_valid = 2'b00;
    repeat (13) step();
    n_tests++;
    if (t_proc_enter !== 1'b1 || t_proc_in !== 8'd3 || t_proc_reset !== 1'b1) begin
      n_fail++; $display("FAIL to_enty: got en=%b in=%0d rst=%b want 1 3 1", t_proc_enter, t_proc_in, t_proc_reset);
    end
    early = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (t_rsp_valid) early = 1'b1;
    end
    n_tests++;
    if (early) begin n_fail++; $display("FAIL to_early: got response before 21 cycles, want none"); end
    step();
    n_tests++;
    if (t_rsp_valid !== 1'b1 || t_rsp_err !== 1'b1 || t_rsp_data !== 8'd0 || t_rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL to_rsp: got v=%b err=%b data=%0d id=%b want 1 1 0 0",
        t_rsp_valid, t_rsp_err, t_rsp_data, t_rsp_id);
    end
    step();
    t_req_valid = 2'b10; t_req1_x = 8'd9; t_req1_y = 8'd6;
    #1;
    n_tests++;
    if (t_rsp_valid !== 1'b0 || t_req_ready !== 2'b10) begin
      n_fail++; $display("FAIL to_next_job: got v=%b ready=%b want 0 10", t_rsp_valid, t_req_ready);
    end
    step(); t_req_valid = 2'b00;
    n_tests++;
    if (t_busy !== 1'b1) begin n_fail++; $display("FAIL to_next_busy: got %b want 1", t_busy); end
  endtask

  // rsp_ready low for 10 cycles on result 13; waiting req1 is not granted meanwhile.
  task automatic test_backpressure();
    bit ok;
    bit bad;
    step();
    rsp_ready = 1'b0;
    req_valid = 2'b11; req0_x = 8'd91; req0_y = 8'd65; req1_x = 8'd30; req1_y = 8'd12;
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_grant: got %b want 01", req_ready); end
    step(); req_valid = 2'b10;
    wait_rsp(400, ok);
    bad = !ok;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 8'd13 || rsp_id !== 1'b0 || rsp_err !== 1'b0 || req_ready !== 2'b00)
        bad = 1'b1;
      if (i < 9) step();
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL bp_hold: got v=%b data=%0d id=%b ready=%b want 1 13 0 00 for 10 cycles",
        rsp_valid, rsp_data, rsp_id, req_ready);
    end
    rsp_ready = 1'b1;
    step();
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin
      n_fail++; $display("FAIL bp_release: got v=%b ready=%b want 0 10", rsp_valid, req_ready);
    end
    step(); req_valid = 2'b00;
    wait_rsp(400, ok);
    n_tests++;
    if (!ok || rsp_data !== 8'd6 || rsp_id !== 1'b1) begin
      n_fail++; $display("FAIL bp_second: got ok=%b data=%0d id=%b want 1 6 1", ok, rsp_data, rsp_id);
    end
  endtask

  // Reset three cycles into RUN: everything drops, no response, req0 wins afterwards.
  task automatic test_reset_midrun();
    bit ok;
    bit bad;
    step();
    req_valid = 2'b01; req0_x = 8'd120; req0_y = 8'd1;
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_grant: got %b want 01", req_ready); end
    step(); req_valid = 2'b00;
    repeat (13) step();
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy, proc_reset, proc_enter, proc_in} !== 24'd0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h want 0",
        {req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy, proc_reset, proc_enter, proc_in});
    end
    req_valid = 2'b11; req0_x = 8'd100; req0_y = 8'd75; req1_x = 8'd81; req1_y = 8'd27;
    bad = 1'b0;
    repeat (3) begin
      step();
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || proc_reset !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL mid_held: got v=%b busy=%b prst=%b want 0 0 0", rsp_valid, busy, proc_reset); end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_regrant: got %b want 01", req_ready); end
    step(); req_valid = 2'b00;
    wait_rsp(400, ok);
    n_tests++;
    if (!ok || rsp_data !== 8'd25 || rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL mid_rsp: got ok=%b data=%0d id=%b want 1 25 0", ok, rsp_data, rsp_id);
    end
  endtask

  task automatic test_random();
    bit ok;
    int a, b;
    logic [1:0] g;
    logic [7:0] exp_d;
    for (int k = 0; k < 100; k++) begin
      a = $urandom_range(127, 1);
      b = $urandom_range(127, 1);
      exp_d = ref_gcd(a, b);
      g = (k % 2 == 0) ? 2'b01 : 2'b10;
      step();
      if (g[1]) begin req1_x = 8'(a); req1_y = 8'(b); end
      else      begin req0_x = 8'(a); req0_y = 8'(b); end
      req_valid = g;
      #1;
      n_tests++;
      if (req_ready !== g) begin n_fail++; $display("FAIL rand_grant%0d: got %b want %b", k, req_ready, g); end
      step(); req_valid = 2'b00;
      wait_rsp(600, ok);
      n_tests++;
      if (!ok || rsp_data !== exp_d || rsp_id !== g[1] || rsp_err !== 1'b0) begin
        n_fail++; $display("FAIL rand_rsp%0d (%0d,%0d): got ok=%b data=%0d id=%b err=%b want 1 %0d %b 0",
          k, a, b, ok, rsp_data, rsp_id, rsp_err, exp_d, g[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_operand();
    test_timeout();
    test_backpressure();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
